// File: rtl/rob_wb_arbiter_if.sv
// Writeback arbiter bus: three requester slices in, one
// registered ROB write out, plus stall feedback and a conflict counter.
interface rob_wb_arbiter_if #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WITDH = 3
);
  logic                         flush;
  logic                         rob_ready;
  logic [2:0]                   req_valid;
  logic [3*ROB_ENTRY_WITDH-1:0] req_rob_id;
  logic [3*WORD_SIZE-1:0]       req_result;
  logic [3*WORD_SIZE-1:0]       req_pc;
  logic [2:0]                   stall;
  logic                         wb_valid;
  logic [ROB_ENTRY_WITDH-1:0]   wb_rob_id;
  logic [WORD_SIZE-1:0]         wb_result;
  logic [WORD_SIZE-1:0]         wb_pc;
  logic [1:0]                   wb_src;
  logic [15:0]                  conflict_cnt;

  modport master (
    output flush, rob_ready, req_valid,
    output req_rob_id, req_result, req_pc,
    input  stall, wb_valid, wb_rob_id,
    input  wb_result, wb_pc, wb_src,
    input  conflict_cnt
  );

  modport slave (
    input  flush, rob_ready, req_valid,
    input  req_rob_id, req_result, req_pc,
    output stall, wb_valid, wb_rob_id,
    output wb_result, wb_pc, wb_src,
    output conflict_cnt
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Round-robin arbiter sharing the single ROB write port between
// ALU, MUL and MEM writeback; losers are stalled in place.
module rob_wb_arbiter #(
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WITDH = 3
) (
  input logic             clk,
  input logic             reset,
  rob_wb_arbiter_if.slave bus
);
  localparam int W = WORD_SIZE;
  localparam int R = ROB_ENTRY_WITDH;

  logic [1:0]   rr_ptr;
  logic [2:0]   grant;
  logic [2:0]   v;
  logic         multi;
  logic [1:0]   sel_src;
  logic [R-1:0] sel_id;
  logic [W-1:0] sel_result;
  logic [W-1:0] sel_pc;

  assign v     = bus.req_valid;
  assign multi = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);

  always_comb begin
    grant = 3'b000;
    if (!bus.flush && bus.rob_ready) begin
      case (rr_ptr)
        2'd1: begin
          if      (v[1]) grant = 3'b010;
          else if (v[2]) grant = 3'b100;
          else if (v[0]) grant = 3'b001;
        end
        2'd2: begin
          if      (v[2]) grant = 3'b100;
          else if (v[0]) grant = 3'b001;
          else if (v[1]) grant = 3'b010;
        end
        default: begin
          if      (v[0]) grant = 3'b001;
          else if (v[1]) grant = 3'b010;
          else if (v[2]) grant = 3'b100;
        end
      endcase
    end
  end

  assign bus.stall = bus.flush ? 3'b000 : (v & ~grant);

  always_comb begin
    sel_src    = 2'd0;
    sel_id     = bus.req_rob_id[R-1:0];
    sel_result = bus.req_result[W-1:0];
    sel_pc     = bus.req_pc[W-1:0];
    unique case (1'b1)
      grant[1]: begin
        sel_src    = 2'd1;
        sel_id     = bus.req_rob_id[R +: R];
        sel_result = bus.req_result[W +: W];
        sel_pc     = bus.req_pc[W +: W];
      end
      grant[2]: begin
        sel_src    = 2'd2;
        sel_id     = bus.req_rob_id[2*R +: R];
        sel_result = bus.req_result[2*W +: W];
        sel_pc     = bus.req_pc[2*W +: W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr           <= 2'd0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rob_id    <= '0;
      bus.wb_result    <= '0;
      bus.wb_pc        <= '0;
      bus.wb_src       <= 2'd0;
      bus.conflict_cnt <= 16'd0;
    end else begin
      bus.wb_valid <= |grant;
      if (|grant) begin
        bus.wb_rob_id <= sel_id;
        bus.wb_result <= sel_result;
        bus.wb_pc     <= sel_pc;
        bus.wb_src    <= sel_src;
        rr_ptr        <= (sel_src == 2'd2) ? 2'd0
                                           : sel_src + 2'd1;
      end
      // counts contention even when the ROB is not ready
      if (multi && !bus.flush &&
          bus.conflict_cnt != 16'hFFFF)
        bus.conflict_cnt <= bus.conflict_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Randomized scoreboard bench for rob_wb_arbiter with a
// round-robin reference model and directed corner cases.
module tb_rob_wb_arbiter;
  typedef struct {
    logic [2:0]  id;
    logic [31:0] res;
    logic [31:0] pc;
    logic [1:0]  src;
  } wb_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;

  rob_wb_arbiter_if #(.WORD_SIZE(32), .ROB_ENTRY_WITDH(3)) bus ();

  rob_wb_arbiter #(.WORD_SIZE(32), .ROB_ENTRY_WITDH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  wb_t         q[$];
  logic [2:0]  v;
  logic [2:0]  id[3];
  logic [31:0] res[3];
  logic [31:0] pc[3];
  bit          fl, rdy;
  int          mptr, mcnt;
  logic [2:0]  last_stall;
  logic [31:0] last_res;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int pick(logic [2:0] vv, int p, bit f, bit r);
    if (f || !r) return -1;
    for (int k = 0; k < 3; k++)
      if (vv[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic apply();
    bus.req_valid  = v;
    bus.req_rob_id = {id[2], id[1], id[0]};
    bus.req_result = {res[2], res[1], res[0]};
    bus.req_pc     = {pc[2], pc[1], pc[0]};
    bus.flush      = fl;
    bus.rob_ready  = rdy;
  endtask

  // called at posedge+1; returns at the following posedge+1
  task automatic step();
    int         g;
    logic [2:0] oh;
    logic [2:0] es;
    apply();
    #1;
    g  = pick(v, mptr, fl, rdy);
    oh = 3'b000;
    if (g >= 0) oh[g] = 1'b1;
    es = fl ? 3'b000 : (v & ~oh);
    check("stall", {61'd0, bus.stall}, {61'd0, es});
    last_stall = es;
    @(posedge clk);
    #1;
    if (g >= 0) begin
      q.push_back('{id[g], res[g], pc[g], 2'(g)});
      mptr = (g + 1) % 3;
    end
    if (!fl && $countones(v) >= 2 && mcnt < 65535) mcnt++;
  endtask

  task automatic randomize_inputs();
    for (int i = 0; i < 3; i++) begin
      if (!last_stall[i]) begin
        v[i]   = ($urandom_range(0, 9) < 6);
        id[i]  = 3'($urandom);
        res[i] = $urandom;
        pc[i]  = $urandom;
      end
    end
    fl  = ($urandom_range(0, 9) == 0);
    rdy = ($urandom_range(0, 3) != 0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && mon_en) begin
      if (q.size() > 0) begin
        wb_t e;
        e = q.pop_front();
        check("wb_valid", {63'd0, bus.wb_valid}, 64'd1);
        if (bus.wb_valid) begin
          check("wb_rob_id", {61'd0, bus.wb_rob_id}, {61'd0, e.id});
          check("wb_result", {32'd0, bus.wb_result}, {32'd0, e.res});
          check("wb_pc", {32'd0, bus.wb_pc}, {32'd0, e.pc});
          check("wb_src", {62'd0, bus.wb_src}, {62'd0, e.src});
        end
        last_res = e.res;
      end else begin
        check("wb_idle", {63'd0, bus.wb_valid}, 64'd0);
        check("wb_hold", {32'd0, bus.wb_result}, {32'd0, last_res});
      end
      check("conflict_cnt", {48'd0, bus.conflict_cnt}, 64'(mcnt));
    end
  end

  initial begin
    mptr = 0; mcnt = 0; last_stall = 3'b000; last_res = '0;
    for (int i = 0; i < 3; i++) begin
      id[i] = '0; res[i] = '0; pc[i] = '0;
    end
    reset = 1'b0;
    v = 3'b011; fl = 0; rdy = 1;
    apply();
    #2;
    check("rst_stall", {61'd0, bus.stall}, 64'b010);
    check("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("rst_wb_result", {32'd0, bus.wb_result}, 64'd0);
    check("rst_wb_src", {62'd0, bus.wb_src}, 64'd0);
    check("rst_cnt", {48'd0, bus.conflict_cnt}, 64'd0);
    @(negedge clk);
    v = 3'b000;
    apply();
    reset = 1'b1;
    mon_en = 1;
    @(posedge clk);
    #1;

    // single ALU result
    v = 3'b001; id[0] = 3'd5; res[0] = 32'hDEAD_BEEF; pc[0] = 32'h100;
    step();
    check("dir_wb_valid", {63'd0, bus.wb_valid}, 64'd1);
    check("dir_wb_result", {32'd0, bus.wb_result}, 64'hDEAD_BEEF);

    // asynchronous reset while a write is presenting
    v = 3'b000;
    apply();
    reset = 1'b0;
    #1;
    check("arst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
    check("arst_wb_result", {32'd0, bus.wb_result}, 64'd0);
    q.delete(); mptr = 0; mcnt = 0; last_res = '0;
    #1;
    reset = 1'b1;

    // three-way contention from rr_ptr 0
    v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      id[i] = 3'(i + 1); res[i] = 32'hA0 + i; pc[i] = 32'h200 + i;
    end
    for (int c = 0; c < 3; c++) begin
      step();
      v = v & last_stall;
    end
    step();

    // ROB not ready, then ready
    v = 3'b010; rdy = 0;
    for (int c = 0; c < 4; c++) step();
    rdy = 1;
    step();
    v = 3'b000;
    step();

    // flush masks grant and contention
    v = 3'b111; fl = 1;
    step();
    fl = 0; v = 3'b000;
    step();

    for (int c = 0; c < 1500; c++) begin
      randomize_inputs();
      step();
    end

    // drive the counter into saturation
    fl = 0; rdy = 0;
    v = 3'b111;
    for (int c = 0; c < 65540; c++) step();
    check("cnt_saturated", {48'd0, bus.conflict_cnt}, 64'hFFFF);

    v = 3'b000; rdy = 1;
    step();
    step();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
